// File: rtl/anf_fl_tex_pkg.sv
// Shared constants, state encoding and helpers for the ETC2 texture block fetcher.
package anf_fl_tex_pkg;

    localparam logic [4:0] FMT_ETC2_RGB   = 5'd1;
    localparam logic [4:0] FMT_ETC2_RGBA8 = 5'd2;

    localparam int BLK_BYTES_8  = 8;
    localparam int BLK_BYTES_16 = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StOutput = 2'd2
    } texStateE;

    function automatic logic isRgba8(input logic [4:0] fmt);
        return fmt == FMT_ETC2_RGBA8;
    endfunction

endpackage

// File: rtl/anf_fl_tex_block_addr.sv
// Combinational byte address of the 4x4 block holding a texel.
module anf_fl_tex_block_addr #(
    parameter int ADDR_W = 32,
    parameter int WB_W   = 10
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [WB_W-1:0]   widthBlocks,
    input  logic [9:0]        uBlk,
    input  logic [9:0]        vBlk,
    input  logic [4:0]        format,
    output logic [ADDR_W-1:0] blockAddr
);
    import anf_fl_tex_pkg::*;

    localparam int IW = 12 + WB_W;
    localparam int OW = IW + 4;

    logic [IW-1:0] idx;
    logic [OW-1:0] off;

    always_comb begin
        idx = IW'(vBlk) * IW'(widthBlocks) + IW'(uBlk);
        off = OW'(idx) * OW'(isRgba8(format) ? BLK_BYTES_16 : BLK_BYTES_8);
        blockAddr = base + ADDR_W'(off);
    end

endmodule

// File: rtl/anf_fl_tex_block_fetch.sv
// Fetches one ETC2 block per texel request and hands it to the decoder.
// Define ANFFL_TEX_BLOCK_CACHE_EN to add a single-entry block cache.
module anf_fl_tex_block_fetch #(
    parameter int ADDR_W = 32,
    parameter int WB_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [11:0]       reqU,
    input  logic [11:0]       reqV,
    input  logic [ADDR_W-1:0] texBase,
    input  logic [WB_W-1:0]   texWidthBlocks,
    input  logic [4:0]        format,
    input  logic              invalidate,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memRespValid,
    input  logic [31:0]       memRespData,
    output logic              outValid,
    input  logic              outReady,
    output logic [127:0]      outData,
    output logic [4:0]        outFormat,
    output logic [1:0]        outUTexel,
    output logic [1:0]        outVTexel
);
    import anf_fl_tex_pkg::*;

    localparam logic [1:0] IDLE   = StIdle;
    localparam logic [1:0] FETCH  = StFetch;
    localparam logic [1:0] OUTPUT = StOutput;

    logic [1:0]        state;
    logic [ADDR_W-1:0] blockAddrC;
    logic              isRgbaR;
    logic [1:0]        issueCnt;
    logic [1:0]        respCnt;
    logic [1:0]        lastBeat;
    logic [1:0]        slot;
    logic [127:0]      newData;
    logic              accept;
    logic              fillDone;
    logic              hit;
    logic [127:0]      cacheData;

    anf_fl_tex_block_addr #(
        .ADDR_W(ADDR_W),
        .WB_W  (WB_W)
    ) uAddr (
        .base       (texBase),
        .widthBlocks(texWidthBlocks),
        .uBlk       (reqU[11:2]),
        .vBlk       (reqV[11:2]),
        .format     (format),
        .blockAddr  (blockAddrC)
    );

    assign reqReady = (state == IDLE);
    assign accept   = reqValid && reqReady;
    assign lastBeat = isRgbaR ? 2'd3 : 2'd1;
    assign fillDone = (state == FETCH) && memRespValid && (respCnt == lastBeat);

    // 8-byte blocks occupy the low half, so their beats start at slot 2
    always_comb begin
        slot    = isRgbaR ? respCnt : respCnt + 2'd2;
        newData = outData;
        unique case (slot)
            2'd0: newData[127:96] = memRespData;
            2'd1: newData[95:64]  = memRespData;
            2'd2: newData[63:32]  = memRespData;
            2'd3: newData[31:0]   = memRespData;
        endcase
    end

`ifdef ANFFL_TEX_BLOCK_CACHE_EN
    logic [ADDR_W-1:0] tagAddr;
    logic [4:0]        tagFmt;
    logic              tagValid;
    logic [127:0]      tagData;
    logic [ADDR_W-1:0] blkAddrR;
    logic              fillOk;

    assign hit = tagValid && !invalidate
              && (tagAddr == blockAddrC) && (tagFmt == format);
    assign cacheData = tagData;

    always_ff @(posedge clk) begin
        if (reset) begin
            tagAddr  <= '0;
            tagFmt   <= '0;
            tagValid <= 1'b0;
            tagData  <= '0;
            blkAddrR <= '0;
            fillOk   <= 1'b0;
        end else begin
            if (accept) begin
                blkAddrR <= blockAddrC;
                fillOk   <= 1'b1;
            end else if (invalidate) begin
                fillOk <= 1'b0;
            end
            if (fillDone) begin
                tagAddr <= blkAddrR;
                tagFmt  <= outFormat;
                tagData <= newData;
            end
            if (invalidate) tagValid <= 1'b0;
            else if (fillDone && fillOk) tagValid <= 1'b1;
        end
    end
`else
    logic unusedInvalidate;
    assign unusedInvalidate = invalidate;
    assign hit       = 1'b0;
    assign cacheData = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            outValid    <= 1'b0;
            memReqValid <= 1'b0;
            memAddr     <= '0;
            outData     <= '0;
            outFormat   <= '0;
            outUTexel   <= '0;
            outVTexel   <= '0;
            issueCnt    <= '0;
            respCnt     <= '0;
            isRgbaR     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        outFormat <= format;
                        outUTexel <= reqU[1:0];
                        outVTexel <= reqV[1:0];
                        isRgbaR   <= isRgba8(format);
                        if (hit) begin
                            state    <= OUTPUT;
                            outValid <= 1'b1;
                            outData  <= cacheData;
                        end else begin
                            state       <= FETCH;
                            memReqValid <= 1'b1;
                            memAddr     <= blockAddrC;
                            issueCnt    <= '0;
                            respCnt     <= '0;
                            outData     <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (memReqValid && memReqReady) begin
                        issueCnt <= issueCnt + 2'd1;
                        if (issueCnt == lastBeat) memReqValid <= 1'b0;
                        else memAddr <= memAddr + ADDR_W'(4);
                    end
                    if (memRespValid) begin
                        respCnt <= respCnt + 2'd1;
                        outData <= newData;
                        if (respCnt == lastBeat) begin
                            state    <= OUTPUT;
                            outValid <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
